// File: rtl/alu_issue_q.sv
// alu_issue_q: in-order command FIFO that feeds an external combinational ALU
// and registers each result behind a valid/ready output stage.
module alu_issue_q #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [3:0]                 in_cond,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [3:0]                 alu_cond,
  input  logic [31:0]                alu_z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_z,
  output logic [3:0]                 out_cond,
  output logic                       out_dz,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]   a_mem [DEPTH];
  logic [31:0]   b_mem [DEPTH];
  logic [3:0]    c_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d, out_dz_q, out_dz_d;
  logic [31:0]   out_z_q, out_z_d;
  logic [3:0]    out_cond_q, out_cond_d;
  logic          has, push, issue, dz;
  // in_ready depends only on occupancy, so out_ready never reaches it combinationally
  always_comb begin
    has         = count_q != '0;
    in_ready    = count_q < CW'(DEPTH);
    push        = in_valid && in_ready;
    issue       = has && (!out_valid_q || out_ready);
    alu_a       = has ? a_mem[rd_ptr_q] : '0;
    alu_b       = has ? b_mem[rd_ptr_q] : '0;
    alu_cond    = has ? c_mem[rd_ptr_q] : '0;
    dz          = (alu_cond == 4'd3 || alu_cond == 4'd4) && alu_b == '0;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(issue);
    out_valid_d = issue || (out_valid_q && !out_ready);
    out_z_d     = issue ? (dz ? '1 : alu_z) : out_z_q;
    out_cond_d  = issue ? alu_cond : out_cond_q;
    out_dz_d    = issue ? dz : out_dz_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_cond_q  <= '0;
      out_dz_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_cond_q  <= out_cond_d;
      out_dz_q    <= out_dz_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q] <= in_a;
      b_mem[wr_ptr_q] <= in_b;
      c_mem[wr_ptr_q] <= in_cond;
    end
  end
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_cond  = out_cond_q;
  assign out_dz    = out_dz_q;
  assign count     = count_q;
endmodule
